// File: rtl/q_meter_pkg.sv
// q_meter_pkg: shared state encoding, default sizes and a width helper for q_meter.
// Q_METER_TIMEOUT_EN adds the ACCUM watchdog.
package q_meter_pkg;

    typedef enum logic [1:0] {SETTLE, ACCUM, DONE} q_meter_state_t;

    localparam int DEF_BUS_WIDTH      = 10;
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_LOG2_AVG       = 2;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    // Bits needed to hold 0..v-1; never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/q_meter_avg.sv
// q_meter_avg: accumulates 2^LOG2_AVG accepted samples and presents their truncated mean.
// done and avg are combinational so the caller can latch the result on the final sample edge.
module q_meter_avg
    import q_meter_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int LOG2_AVG  = DEF_LOG2_AVG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [BUS_WIDTH-1:0] sample,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] avg
);

    localparam int AW = BUS_WIDTH + LOG2_AVG;
    localparam int CW = clog2((1 << LOG2_AVG) + 1);
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2_AVG) - 1);

    logic [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0] cnt_q, cnt_d;

    // clr outranks en so a restart never folds a stale sample into the new run.
    always_comb begin
        sum   = acc_q + AW'(sample);
        done  = en && (cnt_q == LAST);
        avg   = sum[AW-1:LOG2_AVG];
        acc_d = clr ? '0 : en ? sum : acc_q;
        cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/q_meter.sv
// q_meter: waits out analog settling after each i_ref change, then averages Q samples and flags ready.
// Define Q_METER_TIMEOUT_EN to add the ACCUM watchdog and the timeout output.
module q_meter
    import q_meter_pkg::*;
#(
    parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int LOG2_AVG       = DEF_LOG2_AVG
`ifdef Q_METER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic [BUS_WIDTH-1:0] sample,
    input  logic                 sample_valid,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy
`ifdef Q_METER_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int SW = clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);

    q_meter_state_t       state_q, state_d;
    logic [BUS_WIDTH-1:0] i_ref_q, q_q, q_d, avg;
    logic [SW-1:0]        settle_q, settle_d;
    logic                 ready_q, ready_d;
    logic                 chg, avg_clr, avg_en, avg_done;
`ifdef Q_METER_TIMEOUT_EN
    localparam int WW = clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
`endif

    q_meter_avg #(.BUS_WIDTH(BUS_WIDTH), .LOG2_AVG(LOG2_AVG)) u_avg (
        .clk    (clk),
        .rst    (rst),
        .clr    (avg_clr),
        .en     (avg_en),
        .sample (sample),
        .done   (avg_done),
        .avg    (avg)
    );

    // A change of i_ref restarts the measurement ahead of any completion on the same edge.
    always_comb begin
        chg      = i_ref != i_ref_q;
        avg_clr  = chg || (state_q != ACCUM);
        avg_en   = (state_q == ACCUM) && sample_valid;
        state_d  = state_q;
        settle_d = settle_q;
        q_d      = q_q;
        ready_d  = ready_q;
`ifdef Q_METER_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        if (chg) begin
            state_d  = SETTLE;
            settle_d = '0;
            ready_d  = 1'b0;
`ifdef Q_METER_TIMEOUT_EN
            wd_d      = '0;
            timeout_d = 1'b0;
`endif
        end else if (state_q == SETTLE) begin
            state_d  = (settle_q == SETTLE_LAST) ? ACCUM : SETTLE;
            settle_d = (settle_q == SETTLE_LAST) ? settle_q : settle_q + SW'(1);
        end else if ((state_q == ACCUM) && avg_done) begin
            state_d = DONE;
            q_d     = avg;
            ready_d = 1'b1;
        end
`ifdef Q_METER_TIMEOUT_EN
        else if ((state_q == ACCUM) && (wd_q == WD_LAST)) begin
            state_d   = DONE;
            q_d       = '0;
            ready_d   = 1'b1;
            timeout_d = 1'b1;
        end else if (state_q == ACCUM) begin
            wd_d = wd_q + WW'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SETTLE;
            i_ref_q  <= '0;
            settle_q <= '0;
            q_q      <= '0;
            ready_q  <= 1'b0;
`ifdef Q_METER_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            i_ref_q  <= i_ref;
            settle_q <= settle_d;
            q_q      <= q_d;
            ready_q  <= ready_d;
`ifdef Q_METER_TIMEOUT_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign q_measured = q_q;
    assign ready      = ready_q;
    assign busy       = state_q != DONE;
`ifdef Q_METER_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_q_meter.sv
// tb_q_meter: directed stimulus with a scoreboard of expected results checked on every ready rise.
// Build with Q_METER_TIMEOUT_EN to exercise the watchdog path.
module tb_q_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] i_ref = 10'd0;
    logic [9:0] sample = 10'd100;
    logic       sample_valid = 1'b1;
    logic [9:0] q_measured;
    logic       ready, busy;
`ifdef Q_METER_TIMEOUT_EN
    logic       timeout;
`endif

    typedef struct {
        int q;
        int t;
        int at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic ready_prev = 1'b0;

    q_meter dut (
        .clk          (clk),
        .rst          (rst),
        .i_ref        (i_ref),
        .sample       (sample),
        .sample_valid (sample_valid),
        .q_measured   (q_measured),
        .ready        (ready),
        .busy         (busy)
`ifdef Q_METER_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int q, input int t, input int at);
        exp_t e;
        e.q  = q;
        e.t  = t;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < budget);
        chk(name, int'(ready), 1);
    endtask

    // Issue a new i_ref, confirm the drop, then feed four samples after settling.
    task automatic measure(input int iref, input int s0, input int s1, input int s2, input int s3,
                           input int exp_q, input int prev_q);
        int s[4];
        s = '{s0, s1, s2, s3};
        i_ref = 10'(iref);
        sample_valid = 1'b0;
        push_exp(exp_q, 0, cyc + 22);
        @(negedge clk);
        chk("drop_ready", int'(ready), 0);
        chk("drop_q_hold", int'(q_measured), prev_q);
        chk("drop_busy", int'(busy), 1);
        repeat (17) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sample = 10'(s[k]);
            sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        wait_ready("measure_ready", 4);
    endtask

    always @(negedge clk) begin
        if (ready && !ready_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_q_measured", int'(q_measured), e.q);
                chk("sb_ready_cycle", cyc, e.at);
`ifdef Q_METER_TIMEOUT_EN
                chk("sb_timeout", int'(timeout), e.t);
`endif
            end
        end
        ready_prev <= ready;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_q", int'(q_measured), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy", int'(busy), 1);
`ifdef Q_METER_TIMEOUT_EN
        chk("rst_timeout", int'(timeout), 0);
`endif
        // Auto-start after reset release: 16 settle + 1 transition + 4 samples.
        rst = 1'b1;
        push_exp(100, 0, cyc + 21);
        wait_ready("t1_ready", 30);
        chk("t1_busy", int'(busy), 0);
        // 10+11+12+13 = 46, 46/4 = 11.
        measure(512, 10, 11, 12, 13, 11, 100);
        // Abort five cycles into ACCUM with partial samples of 1000.
        i_ref = 10'd300;
        sample_valid = 1'b0;
        repeat (18) @(negedge clk);
        sample = 10'd1000;
        sample_valid = 1'b1;
        repeat (3) @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_mid_ready", int'(ready), 0);
        chk("t3_mid_q", int'(q_measured), 11);
        chk("t3_mid_busy", int'(busy), 1);
        // 20+20+20+24 = 84, 84/4 = 21; stale 1000s would change it.
        measure(301, 20, 20, 20, 24, 21, 11);
        // i_ref change on the same edge as the 4th sample.
        i_ref = 10'd400;
        sample_valid = 1'b0;
        repeat (18) @(negedge clk);
        sample = 10'd50;
        sample_valid = 1'b1;
        repeat (3) @(negedge clk);
        i_ref = 10'd401;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("t4_q_hold", int'(q_measured), 21);
        chk("t4_ready", int'(ready), 0);
        chk("t4_busy", int'(busy), 1);
        // 40+41+42+43 = 166, 166/4 = 41 truncated.
        measure(402, 40, 41, 42, 43, 41, 21);
        // Asynchronous reset in the middle of ACCUM, checked between edges.
        i_ref = 10'd700;
        sample_valid = 1'b0;
        repeat (18) @(negedge clk);
        sample = 10'd5;
        sample_valid = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_q", int'(q_measured), 0);
        chk("t6_async_ready", int'(ready), 0);
        chk("t6_async_busy", int'(busy), 1);
`ifdef Q_METER_TIMEOUT_EN
        chk("t6_async_timeout", int'(timeout), 0);
`endif
        @(negedge clk);
        i_ref = 10'd0;
        sample = 10'd77;
        sample_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        push_exp(77, 0, cyc + 21);
        wait_ready("t6_restart_ready", 30);
        // No valid samples at all during ACCUM.
        i_ref = 10'd600;
        sample_valid = 1'b0;
`ifdef Q_METER_TIMEOUT_EN
        push_exp(0, 1, cyc + 274);
        wait_ready("t5_timeout_ready", 300);
        chk("t5_busy", int'(busy), 0);
`else
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk("t5_no_ready", cnt, 0);
        chk("t5_busy", int'(busy), 1);
`endif
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
